// File: rtl/state_pack__unmask.sv
// state_pack__unmask
// Recombines two arithmetic shares of an 8-coefficient Kyber slice,
// reduces each coefficient mod KYBER_Q with a fixed-latency Barrett
// pipeline and packs the results into 96 bits of 12-bit coefficients.
module state_pack__unmask #(
    parameter int KYBER_Q = 3329
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable,
    input  logic [127:0] s1,
    input  logic [127:0] s2,
    output logic         function_done,
    output logic [95:0]  p
);

    // Barrett multiplier floor(2^28 / Q); it never overestimates the
    // quotient, so the stage-A remainder is always non-negative.
    localparam int          BARRETT_M = (1 << 28) / KYBER_Q;
    localparam logic [33:0] M34       = 34'(BARRETT_M);
    localparam logic [33:0] Q34       = 34'(KYBER_Q);
    localparam logic [13:0] Q14       = 14'(KYBER_Q);
    localparam logic [13:0] Q2_14     = 14'(2 * KYBER_Q);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Stage A: sum - floor(sum*M / 2^28)*Q, result lies in [0, 3Q)
    function automatic logic [13:0] barrett_est(input logic [16:0] s);
        logic [33:0] prod;
        logic [33:0] eq;
        prod = {17'd0, s} * M34;
        eq   = (prod >> 28) * Q34;
        return 14'({17'd0, s} - eq);
    endfunction

    // Stage B: at most two conditional subtractions bring r below Q
    function automatic logic [11:0] cond_sub(input logic [13:0] r);
        logic [13:0] t;
        if (r >= Q2_14)    t = r - Q2_14;
        else if (r >= Q14) t = r - Q14;
        else               t = r;
        return 12'(t);
    endfunction

    logic [1:0]   state_q, state_d;
    logic [2:0]   m_q, m_d;
    logic         done_q, done_d;
    logic         cap, issue;
    logic [127:0] s1_q, s2_q;
    logic [15:0]  c1, c2;
    logic [16:0]  sum_p0_q;
    logic         vld_p0_q;
    logic [2:0]   idx_p0_q;
    logic [13:0]  r_p1_q;
    logic         vld_p1_q;
    logic [2:0]   idx_p1_q;
    logic [11:0]  red_p2;
    logic [95:0]  p_q;

    // Sequencer: IDLE -> RUN (8 issues) -> DRAIN (2) -> DONE (1) -> IDLE
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        done_d  = 1'b0;
        cap     = 1'b0;
        issue   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    cap     = 1'b1;
                    m_d     = 3'd0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                issue = 1'b1;
                if (m_q == 3'd7) begin
                    m_d     = 3'd0;
                    state_d = ST_DRAIN;
                end else begin
                    m_d = m_q + 3'd1;
                end
            end
            ST_DRAIN: begin
                if (m_q == 3'd1) begin
                    m_d     = 3'd0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    m_d = m_q + 3'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Select share coefficient m from the captured (MSB-first) slices
    always_comb begin
        c1 = 16'd0;
        c2 = 16'd0;
        for (int i = 0; i < 8; i++) begin
            if (m_q == 3'(i)) begin
                c1 = s1_q[127-16*i -: 16];
                c2 = s2_q[127-16*i -: 16];
            end
        end
    end

    assign red_p2 = cond_sub(r_p1_q);

    // Control registers: state, index, completion pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            m_q     <= 3'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            done_q  <= done_d;
        end
    end

    // Share capture, so later input changes cannot disturb the operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else if (cap) begin
            s1_q <= s1;
            s2_q <= s2;
        end
    end

    // Stage p0: unmasking sum; p1: Barrett estimate; p2: final write into p
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_p0_q <= '0;
            vld_p0_q <= 1'b0;
            idx_p0_q <= 3'd0;
            r_p1_q   <= '0;
            vld_p1_q <= 1'b0;
            idx_p1_q <= 3'd0;
            p_q      <= '0;
        end else begin
            vld_p0_q <= issue;
            if (issue) begin
                sum_p0_q <= {1'b0, c1} + {1'b0, c2};
                idx_p0_q <= m_q;
            end
            vld_p1_q <= vld_p0_q;
            if (vld_p0_q) begin
                r_p1_q   <= barrett_est(sum_p0_q);
                idx_p1_q <= idx_p0_q;
            end
            if (vld_p1_q) begin
                for (int i = 0; i < 8; i++) begin
                    if (idx_p1_q == 3'(i)) p_q[95-12*i -: 12] <= red_p2;
                end
            end
        end
    end

    assign function_done = done_q;
    assign p             = p_q;

endmodule

// File: doc/state_pack__unmask.md
# state_pack__unmask

Recombines the two arithmetic shares of a masked 8-coefficient Kyber state slice into the unmasked value, reduces it mod KYBER_Q, and packs it into 96 bits of 12-bit coefficients. It sits directly downstream of the state-unpack masking stage and consumes its `s1`/`s2` outputs: `s1` is the random share and `s2` is `(s - s1) mod Q`. It uses no divider IP. Reduction is an exact, fixed-latency 2-stage pipeline, so total latency is constant and independent of the data.

## Interface
- KYBER_Q, 3329, modulus; must be < 4096 so a reduced coefficient fits in 12 bits.
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  start request; sampled only in IDLE.
- s1  input  128  share 1; coefficient i at s1[127-16i -: 16], i=0..7 (MSB-first); any 16-bit value is legal.
- s2  input  128  share 2; same layout as s1; any 16-bit value is legal.
- function_done  output  1  one-cycle completion pulse.
- p  output  96  packed result; coefficient i at p[95-12i -: 12].

## Operation
- States:
  - IDLE: if `enable`, capture `s1`/`s2` into internal registers, clear coefficient index m to 0, go to RUN.
  - RUN: 8 cycles; issue coefficient m (m = 0..7) into the pipeline, one per cycle; go to DRAIN after m = 7.
  - DRAIN: 2 cycles; flush the pipeline.
  - DONE: 1 cycle; return to IDLE.
- Arithmetic, per coefficient:
  - sum = s1_i + s2_i, a 17-bit zero-extended sum (max 131070).
  - result = sum mod KYBER_Q, exact for every input pair.
  - Stage A: Barrett quotient estimate, floor(sum*80635 / 2^28), then r = sum - estimate*Q.
  - Stage B: conditional subtractions of Q until r < Q; at most 2 are required.
  - Write r[11:0] into p slot i.
  - No other rounding or compression.
- Inputs are used only from the internal capture registers. Changes on `s1`/`s2`/`enable` after the capture edge have no effect on the running operation.
- `enable` outside IDLE is ignored.
- p slots are overwritten progressively during an operation. p holds its last value between operations.

## Timing
- Edge numbering: edge 0 is the rising edge at which IDLE samples enable = 1.
- Edges 1..8: coefficients 0..7 are issued to stage A.
- Coefficient i is written into p at edge 3+i, so slot 7 is written at edge 10.
- function_done is registered 1 at edge 10 and cleared at edge 11, i.e. high for exactly one cycle. p is complete and stable while function_done is high.
- State becomes IDLE at edge 11. If enable is still high, the next capture occurs at edge 12, giving back-to-back operations every 12 cycles.
- Reset values: function_done = 0, p = 96'd0, state = IDLE, m = 0, pipeline valid bits = 0.
- Reset asserted mid-operation:
  - Immediately aborts the operation and clears all registers.
  - No function_done pulse is produced for the aborted operation.
  - The first operation after reset release behaves normally.
- enable = 0 in IDLE: stay idle; function_done = 0; p unchanged.

## Test plan
- Reset: hold rst_n = 0 with random inputs -> p = 0 and function_done = 0. Release with enable = 0 -> values unchanged for 20 cycles.
- Identity: s1 = 0, s2 coefficients {0, 1, 2, 100, 1234, 3000, 3327, 3328} -> p = {000, 001, 002, 064, 4D2, BB8, CFF, D00} (hex). function_done is high exactly in the cycle after edge 10.
- Masked input from upstream: s1_i = 0xFFFF, s2_i = 2279 for all i -> every p slot = 1234 (0x4D2).
- Maximum sum: s1 = s2 = all 0xFFFF -> every slot = 1239 (0x4D7). Also cover s1_i + s2_i = 3329 -> 0 and = 6658 -> 0.
- Back-to-back: enable held high; change s1/s2 during the first operation -> pulses 12 cycles apart.
  - First result matches the inputs captured at edge 0.
  - Second result matches the inputs present at edge 12.
- Abort: assert rst_n = 0 at edge 5 of an operation -> p = 0 and no pulse. Then a fresh operation with identity vectors -> correct p at edge 10.
